value_change_fifo: RTL and testbench
====================================

// Module: value_change_fifo
// PURPOSE
//   Downstream consumer of an 8-bit registered value bus (e.g. XOUT of the
//   sensitivity/edge stage). Samples the bus every CLK, detects value changes,
//   queues each new value in a small FIFO and presents it on a valid/ready port.
//   Counts changes lost to a full FIFO; feeds event logging / host readout.
// PARAMETERS
//   WIDTH      8   width of sampled value and FIFO word
//   DEPTH      4   FIFO entries; power of 2, >= 2
//   CNT_WIDTH  8   width of DROP_COUNT (saturating)
// PORTS
//   CLK        in   1          clock, all state on rising edge
//   RESET      in   1          asynchronous, active-low reset (0 = reset)
//   EN         in   1          sampling enable
//   CLEAR      in   1          sync clear of DROP_COUNT and OVERFLOW
//   XIN        in   WIDTH      monitored value (upstream XOUT)
//   OUT_DATA   out  WIDTH      head-of-FIFO value (first-word fall-through)
//   OUT_VALID  out  1          FIFO non-empty
//   OUT_READY  in   1          consumer accepts OUT_DATA this cycle
//   DROP_COUNT out  CNT_WIDTH  changes dropped since reset/CLEAR, saturates
//   OVERFLOW   out  1          sticky: at least one drop since reset/CLEAR
// BEHAVIOUR
//   Reset (RESET=0, async): OUT_VALID=0, OUT_DATA=0, DROP_COUNT=0, OVERFLOW=0;
//     FIFO pointers/count=0, PRIMED=0, reference register LAST=0.
//   Priming: EN=1 & PRIMED=0 -> LAST<=XIN, PRIMED<=1, no push.
//   EN=0 -> PRIMED<=0, no push; FIFO still drains. Re-enable re-primes.
//   Change: EN=1 & PRIMED=1 & XIN!=LAST -> push XIN, LAST<=XIN.
//   Latency: change sampled at edge N -> OUT_VALID=1, OUT_DATA=XIN at N+1.
//   Pop: OUT_VALID & OUT_READY at an edge -> head removed. OUT_READY while
//     OUT_VALID=0 is ignored. OUT_DATA stable while OUT_VALID & !OUT_READY.
//   Full (count==DEPTH): push with no pop -> value dropped, LAST still
//     updated, DROP_COUNT+1 (hold at 2^CNT_WIDTH-1), OVERFLOW<=1.
//   Full with simultaneous push and pop: both occur, count stays DEPTH, no drop.
//   Empty with simultaneous push and pop: pop ignored (OUT_VALID was 0).
//   Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//   CLEAR & drop same cycle: CLEAR wins -> DROP_COUNT=0, OVERFLOW=0.
//   CLEAR does not affect FIFO contents, LAST or PRIMED.
//   OUT_DATA when empty: last head value, don't-care; bench must not check it.
//   Reset asserted mid-transfer: FIFO discarded immediately, outputs to reset
//     values asynchronously; first edge after release behaves as post-reset.
// STRUCTURE
//   Package value_change_pkg: localparam defaults, function clog2-based
//     PTR_W(DEPTH) helper; no struct typedefs needed.
//   Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, count, full/empty,
//     FWFT read; push/pop inputs, same CLK/RESET. Top holds LAST, PRIMED,
//     change detect, drop counter, OVERFLOW.
// TESTING
//   1 Reset, EN=1, XIN=0x05 held 5 cycles -> no OUT_VALID; DROP_COUNT=0.
//   2 Primed on 0x05; XIN 0x06,0x07,0x07,0x09 on successive edges,
//     OUT_READY=1 -> OUT_DATA 0x06,0x07,0x09 each one cycle after its edge.
//   3 OUT_READY=0, DEPTH=4, six distinct changes -> OUT_VALID=1, first four
//     values queued, DROP_COUNT=2, OVERFLOW=1; then CLEAR -> both 0, FIFO intact.
//   4 FIFO full, push and pop on same edge -> count stays 4, no drop, head
//     advances to 2nd entry, new value at tail.
//   5 Drops forced 260 times with CNT_WIDTH=8 -> DROP_COUNT=255, holds.
//   6 RESET pulsed low mid-stream with 3 entries queued, no CLK edge during
//     pulse -> OUT_VALID=0 immediately; after release first EN cycle primes
//     only, no push.

Source files
------------

// File: rtl/value_change_pkg.sv
// Shared defaults and sizing helper for the value-change capture block.
package value_change_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int CNT_WIDTH_DEF = 8;

    // Pointer width for a power-of-two FIFO depth; a depth of 1 still gets one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and full/empty flags.
module sync_fifo
    import value_change_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/value_change_fifo.sv
// Watches a registered value bus, queues each new value and counts changes lost to a full queue.
module value_change_fifo
    import value_change_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 CLEAR,
    input  logic [WIDTH-1:0]     XIN,
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [CNT_WIDTH-1:0] DROP_COUNT,
    output logic                 OVERFLOW
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0] last_val;
    logic             primed;
    logic             change;
    logic             drop;
    logic             full;
    logic             empty;

    assign change    = EN & primed & (XIN != last_val);
    // Full means non-empty, so a ready consumer always frees a slot for this push.
    assign drop      = change & full & ~OUT_READY;
    assign OUT_VALID = ~empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (change),
        .pop     (OUT_READY),
        .wr_data (XIN),
        .rd_data (OUT_DATA),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_val   <= '0;
            primed     <= 1'b0;
            DROP_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            primed <= EN;
            // Tracking XIN whenever enabled covers both priming and change updates.
            if (EN) begin
                last_val <= XIN;
            end
            if (CLEAR) begin
                DROP_COUNT <= '0;
                OVERFLOW   <= 1'b0;
            end else if (drop) begin
                if (DROP_COUNT != CNT_MAX) begin
                    DROP_COUNT <= DROP_COUNT + CNT_WIDTH'(1);
                end
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_value_change_fifo.sv
// Scoreboard bench for value_change_fifo: directed vectors, queued expectations, decoupled monitor.
module tb_value_change_fifo;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic       CLEAR;
    logic [7:0] XIN;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] DROP_COUNT;
    logic       OVERFLOW;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] sb [$];

    value_change_fifo #(.WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .EN         (EN),
        .CLEAR      (CLEAR),
        .XIN        (XIN),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .DROP_COUNT (DROP_COUNT),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Inputs are applied just after an edge and sampled at the next one.
    task automatic cycle(input logic en, input logic clr, input logic [7:0] x, input logic rdy);
        EN = en; CLEAR = clr; XIN = x; OUT_READY = rdy;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every accepted transfer must match the next queued value.
    always @(negedge CLK) begin
        if (RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_transfer", {24'd0, OUT_DATA}, 32'hFFFF_FFFF);
            end else begin
                check("out_data", {24'd0, OUT_DATA}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int valid_seen;
        RESET = 1'b0; EN = 1'b0; CLEAR = 1'b0; XIN = 8'h00; OUT_READY = 1'b0;
        #1;
        check("rst_valid",    OUT_VALID,  0);
        check("rst_data",     OUT_DATA,   0);
        check("rst_drop",     DROP_COUNT, 0);
        check("rst_overflow", OVERFLOW,   0);
        #6 RESET = 1'b1;

        // 1: priming only, constant input never queues anything
        valid_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 8'h05, 1);
            if (OUT_VALID) valid_seen++;
        end
        check("t1_no_valid", valid_seen, 0);
        check("t1_drop",     DROP_COUNT, 0);

        // 2: changes appear one cycle after their sampling edge
        sb.push_back(8'h06); cycle(1, 0, 8'h06, 1);
        check("t2_valid_06", OUT_VALID, 1);
        check("t2_data_06",  OUT_DATA,  8'h06);
        sb.push_back(8'h07); cycle(1, 0, 8'h07, 1);
        check("t2_data_07",  OUT_DATA,  8'h07);
        cycle(1, 0, 8'h07, 1);
        check("t2_repeat_empty", OUT_VALID, 0);
        sb.push_back(8'h09); cycle(1, 0, 8'h09, 1);
        check("t2_data_09",  OUT_DATA,  8'h09);
        cycle(1, 0, 8'h09, 1);
        check("t2_drained",  OUT_VALID, 0);

        // 3: six changes into a depth-4 FIFO with no consumer
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back(8'h10 + 8'(i));
            cycle(1, 0, 8'h10 + 8'(i), 0);
        end
        check("t3_valid",    OUT_VALID,  1);
        check("t3_head",     OUT_DATA,   8'h10);
        check("t3_drop",     DROP_COUNT, 2);
        check("t3_overflow", OVERFLOW,   1);
        cycle(1, 1, 8'h15, 0);
        check("t3_clr_drop", DROP_COUNT, 0);
        check("t3_clr_ovf",  OVERFLOW,   0);
        check("t3_clr_head", OUT_DATA,   8'h10);
        // a drop on the same edge as CLEAR leaves both cleared
        cycle(1, 1, 8'h16, 0);
        check("t3_clr_wins_drop", DROP_COUNT, 0);
        check("t3_clr_wins_ovf",  OVERFLOW,   0);

        // 4: full FIFO, push and pop on the same edge
        sb.push_back(8'h20); cycle(1, 0, 8'h20, 1);
        check("t4_head",  OUT_DATA,   8'h11);
        check("t4_drop",  DROP_COUNT, 0);
        cycle(1, 0, 8'h21, 0);
        check("t4_still_full", DROP_COUNT, 1);

        // 5: drop counter saturates
        cycle(1, 1, 8'h21, 0);
        for (int i = 0; i < 255; i++) cycle(1, 0, (i % 2 == 1) ? 8'h41 : 8'h40, 0);
        check("t5_drop_255", DROP_COUNT, 255);
        for (int i = 255; i < 260; i++) cycle(1, 0, (i % 2 == 1) ? 8'h41 : 8'h40, 0);
        check("t5_drop_hold", DROP_COUNT, 255);
        check("t5_overflow",  OVERFLOW,   1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'h41, 1);
        check("t5_drained", OUT_VALID, 0);

        // 6: asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'h50 + 8'(i));
            cycle(1, 0, 8'h50 + 8'(i), 0);
        end
        check("t6_valid_before", OUT_VALID, 1);
        #2 RESET = 1'b0;
        #1;
        check("t6_rst_valid", OUT_VALID,  0);
        check("t6_rst_drop",  DROP_COUNT, 0);
        check("t6_rst_ovf",   OVERFLOW,   0);
        sb.delete();
        #2 RESET = 1'b1;
        cycle(1, 0, 8'h60, 1);
        check("t6_prime_only", OUT_VALID, 0);
        sb.push_back(8'h61); cycle(1, 0, 8'h61, 1);
        check("t6_push_valid", OUT_VALID, 1);
        check("t6_push_data",  OUT_DATA,  8'h61);

        // EN low drops priming; re-enable primes before detecting again
        cycle(0, 0, 8'h70, 1);
        check("en_off_no_push", OUT_VALID, 0);
        cycle(1, 0, 8'h71, 1);
        check("reprime_no_push", OUT_VALID, 0);
        sb.push_back(8'h72); cycle(1, 0, 8'h72, 1);
        check("reprime_push", OUT_DATA, 8'h72);
        cycle(1, 0, 8'h72, 1);
        cycle(1, 0, 8'h72, 1);
        check("final_empty",   OUT_VALID, 0);
        check("sb_all_popped", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
